// File: rtl/fault_injector_not_pkg.sv
// Shared definitions for the inverter fault injector: FSM encoding and fault codes.
package fault_injector_not_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [2:0] CLR   = 3'd0;
  localparam logic [2:0] A_SA0 = 3'd1;
  localparam logic [2:0] A_SA1 = 3'd2;
  localparam logic [2:0] Z_SA0 = 3'd3;
  localparam logic [2:0] Z_SA1 = 3'd4;
  localparam logic [2:0] A1_Z1 = 3'd5;

  // Codes 6 and 7 have no fault behaviour defined and are flagged as errors.
  function automatic logic is_illegal(input logic [2:0] code);
    return code > A1_Z1;
  endfunction

endpackage

// File: rtl/fault_injector_not_mux.sv
// Combinational inverter datapath with stuck-at overrides on the A input and Z output.
module fault_mux_not
  import fault_injector_not_pkg::*;
(
  input  logic       a_in,
  input  logic [2:0] fault_code,
  output logic       a_eff,
  output logic       z_out
);

  always_comb begin
    a_eff = a_in;
    case (fault_code)
      A_SA0:        a_eff = 1'b0;
      A_SA1, A1_Z1: a_eff = 1'b1;
      default:      a_eff = a_in;
    endcase
  end

  always_comb begin
    z_out = ~a_eff;
    case (fault_code)
      Z_SA0:        z_out = 1'b0;
      Z_SA1, A1_Z1: z_out = 1'b1;
      default:      z_out = ~a_eff;
    endcase
  end

endmodule

// File: rtl/fault_injector_not.sv
// Command-driven fault injector around an inverter: accepts a fault code, arms it
// for ARM_DELAY cycles, then applies it for a fixed duration or until cleared.
module fault_injector_not
  import fault_injector_not_pkg::*;
#(
  parameter int ARM_DELAY = 2,
  parameter int DUR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  output logic             z_out,
  output logic             a_eff,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_code,
  input  logic [DUR_W-1:0] cmd_dur,
  output logic             active,
  output logic [2:0]       fault_state,
  output logic             done,
  output logic             err,
  output logic [7:0]       inj_count
);

  localparam logic [3:0] ARM_LAST = 4'((ARM_DELAY == 0) ? 0 : ARM_DELAY - 1);

  state_t           state;
  state_t           next_state;
  logic [3:0]       arm_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             perm_q;
  logic [2:0]       code_q;

  logic accept;
  logic start_fault;
  logic clear_req;
  logic expire;

  assign accept      = cmd_valid && cmd_ready;
  assign start_fault = accept && (state == ST_IDLE) && (cmd_code != CLR) && !is_illegal(cmd_code);
  assign clear_req   = accept && (state == ST_ACTIVE) && (cmd_code == CLR);
  assign expire      = (state == ST_ACTIVE) && !perm_q && (dur_cnt == DUR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_fault) next_state = (ARM_DELAY == 0) ? ST_ACTIVE : ST_ARM;
      ST_ARM:    if (arm_cnt == ARM_LAST) next_state = ST_ACTIVE;
      ST_ACTIVE: if (clear_req || expire) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Ready is forced low while reset is held so no command can slip in during reset.
  always_comb begin
    cmd_ready   = rst_n && (state != ST_ARM);
    active      = (state == ST_ACTIVE);
    fault_state = active ? code_q : CLR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                arm_cnt <= '0;
    else if (state == ST_ARM)  arm_cnt <= arm_cnt + 4'd1;
    else                       arm_cnt <= '0;
  end

  // A duration of zero marks the fault permanent; otherwise count down each active cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= CLR;
      dur_cnt <= '0;
      perm_q  <= 1'b0;
    end else if (start_fault) begin
      code_q  <= cmd_code;
      dur_cnt <= cmd_dur;
      perm_q  <= (cmd_dur == '0);
    end else if ((state == ST_ACTIVE) && !perm_q) begin
      dur_cnt <= dur_cnt - DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      err       <= 1'b0;
      inj_count <= '0;
    end else begin
      done <= (state == ST_ACTIVE) && (next_state == ST_IDLE);
      if (accept && is_illegal(cmd_code)) err <= 1'b1;
      if ((state != ST_ACTIVE) && (next_state == ST_ACTIVE) && (inj_count != 8'hFF))
        inj_count <= inj_count + 8'd1;
    end
  end

  fault_mux_not u_mux (
    .a_in       (a_in),
    .fault_code (fault_state),
    .a_eff      (a_eff),
    .z_out      (z_out)
  );

endmodule

// File: tb/tb_fault_injector_not.sv
// Directed self-checking bench for fault_injector_not (ARM_DELAY=2 and ARM_DELAY=0 instances).
module tb_fault_injector_not;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       cmd_valid;
  logic       cmd_valid0;
  logic [2:0] cmd_code;
  logic [7:0] cmd_dur;

  logic       z_out, a_eff, cmd_ready, active, done, err;
  logic [2:0] fault_state;
  logic [7:0] inj_count;

  logic       z_out0, a_eff0, cmd_ready0, active0, done0, err0;
  logic [2:0] fault_state0;
  logic [7:0] inj_count0;

  int total;
  int bad;

  fault_injector_not #(.ARM_DELAY(2), .DUR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .z_out(z_out), .a_eff(a_eff),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_dur(cmd_dur),
    .active(active), .fault_state(fault_state), .done(done), .err(err), .inj_count(inj_count)
  );

  fault_injector_not #(.ARM_DELAY(0), .DUR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .z_out(z_out0), .a_eff(a_eff0),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_code(cmd_code), .cmd_dur(cmd_dur),
    .active(active0), .fault_state(fault_state0), .done(done0), .err(err0), .inj_count(inj_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b exp=0", active); end
    total++; if (fault_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_fault_state got=%0d exp=0", fault_state); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_done_err got=%b%b exp=00", done, err); end
    total++; if (inj_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_inj_count got=%0d exp=0", inj_count); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_low got=%b exp=0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1 || cmd_ready0 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_high got=%b%b exp=11", cmd_ready, cmd_ready0); end
  endtask

  task automatic test_idle_inverter();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in = i[0];
      #1;
      total++; if (z_out !== ~a_in) begin bad++; $display("[TB] FAIL idle_z a_in=%b got=%b exp=%b", a_in, z_out, ~a_in); end
      total++; if (active !== 1'b0 || inj_count !== 8'd0) begin bad++; $display("[TB] FAIL idle_state active=%b inj=%0d exp=0/0", active, inj_count); end
    end
  endtask

  // Code 4 for 3 cycles accepted in cycle 0: ARM in 1..2, active 3..5, done in 6.
  task automatic test_timed_fault();
    logic exp_act, exp_z, exp_done, exp_rdy;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd4; cmd_dur = 8'd3;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      a_in = c[0];
      #1;
      exp_act  = (c >= 3 && c <= 5);
      exp_z    = exp_act ? 1'b1 : ~a_in;
      exp_done = (c == 6);
      exp_rdy  = !(c == 1 || c == 2);
      total++; if (active !== exp_act) begin bad++; $display("[TB] FAIL timed_active cyc=%0d got=%b exp=%b", c, active, exp_act); end
      total++; if (z_out !== exp_z) begin bad++; $display("[TB] FAIL timed_z cyc=%0d got=%b exp=%b", c, z_out, exp_z); end
      total++; if (done !== exp_done) begin bad++; $display("[TB] FAIL timed_done cyc=%0d got=%b exp=%b", c, done, exp_done); end
      total++; if (cmd_ready !== exp_rdy) begin bad++; $display("[TB] FAIL timed_ready cyc=%0d got=%b exp=%b", c, cmd_ready, exp_rdy); end
      total++; if (fault_state !== (exp_act ? 3'd4 : 3'd0)) begin bad++; $display("[TB] FAIL timed_fault_state cyc=%0d got=%0d", c, fault_state); end
    end
    total++; if (inj_count !== 8'd1) begin bad++; $display("[TB] FAIL timed_inj_count got=%0d exp=1", inj_count); end
  endtask

  task automatic test_permanent_clear();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd5; cmd_dur = 8'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      a_in = c[0];
      #1;
      if (c >= 3) begin
        total++; if (a_eff !== 1'b1 || z_out !== 1'b1) begin bad++; $display("[TB] FAIL perm_held cyc=%0d a_eff=%b z=%b exp=1/1", c, a_eff, z_out); end
      end
    end
    cmd_valid = 1'b1; cmd_code = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    a_in = 1'b0;
    #1;
    total++; if (active !== 1'b0 || z_out !== 1'b1 || done !== 1'b1) begin bad++; $display("[TB] FAIL perm_clear active=%b z=%b done=%b exp=0/1/1", active, z_out, done); end
    @(negedge clk);
    a_in = 1'b1;
    #1;
    total++; if (done !== 1'b0 || z_out !== 1'b0) begin bad++; $display("[TB] FAIL perm_after done=%b z=%b exp=0/0", done, z_out); end
    total++; if (inj_count !== 8'd2) begin bad++; $display("[TB] FAIL perm_inj_count got=%0d exp=2", inj_count); end
  endtask

  task automatic test_ignore_illegal();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd1; cmd_dur = 8'd0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in = 1'b1;
    #1;
    total++; if (fault_state !== 3'd1 || a_eff !== 1'b0 || z_out !== 1'b1) begin bad++; $display("[TB] FAIL ign_active fs=%0d a_eff=%b z=%b exp=1/0/1", fault_state, a_eff, z_out); end
    cmd_valid = 1'b1; cmd_code = 3'd3;
    @(negedge clk);
    #1;
    total++; if (fault_state !== 3'd1 || err !== 1'b0 || z_out !== 1'b1) begin bad++; $display("[TB] FAIL ign_code3 fs=%0d err=%b z=%b exp=1/0/1", fault_state, err, z_out); end
    cmd_code = 3'd7;
    @(negedge clk);
    #1;
    total++; if (err !== 1'b1 || fault_state !== 3'd1) begin bad++; $display("[TB] FAIL ign_code7 err=%b fs=%0d exp=1/1", err, fault_state); end
    cmd_code = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    total++; if (done !== 1'b1 || active !== 1'b0 || err !== 1'b1) begin bad++; $display("[TB] FAIL ign_clear done=%b active=%b err=%b exp=1/0/1", done, active, err); end
  endtask

  task automatic test_reset_mid_active();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd2; cmd_dur = 8'd10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    a_in = 1'b0;
    #1;
    total++; if (active !== 1'b1 || fault_state !== 3'd2 || z_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_pre active=%b fs=%0d z=%b exp=1/2/0", active, fault_state, z_out); end
    rst_n = 1'b0;
    #1;
    total++; if (active !== 1'b0 || fault_state !== 3'd0 || z_out !== 1'b1) begin bad++; $display("[TB] FAIL rst_async active=%b fs=%0d z=%b exp=0/0/1", active, fault_state, z_out); end
    total++; if (inj_count !== 8'd0 || err !== 1'b0) begin bad++; $display("[TB] FAIL rst_counters inj=%0d err=%b exp=0/0", inj_count, err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      total++; if (done !== 1'b0 || active !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_done cyc=%0d done=%b active=%b exp=0/0", c, done, active); end
    end
  endtask

  task automatic test_zero_delay();
    @(negedge clk);
    cmd_valid0 = 1'b1; cmd_code = 3'd3; cmd_dur = 8'd1;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    a_in = 1'b0;
    #1;
    total++; if (active0 !== 1'b1 || z_out0 !== 1'b0 || fault_state0 !== 3'd3) begin bad++; $display("[TB] FAIL zd_active active=%b z=%b fs=%0d exp=1/0/3", active0, z_out0, fault_state0); end
    @(negedge clk);
    #1;
    total++; if (active0 !== 1'b0 || done0 !== 1'b1 || z_out0 !== 1'b1) begin bad++; $display("[TB] FAIL zd_done active=%b done=%b z=%b exp=0/1/1", active0, done0, z_out0); end
    @(negedge clk);
    #1;
    total++; if (done0 !== 1'b0 || inj_count0 !== 8'd1) begin bad++; $display("[TB] FAIL zd_after done=%b inj=%0d exp=0/1", done0, inj_count0); end
  endtask

  // Duration expiry and a clear command land on the same cycle: one done, one return to idle.
  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid0 = 1'b1; cmd_code = 3'd4; cmd_dur = 8'd2;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    #1;
    total++; if (active0 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first active=%b exp=1", active0); end
    @(negedge clk);
    cmd_valid0 = 1'b1; cmd_code = 3'd0;
    #1;
    total++; if (active0 !== 1'b1 || done0 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_last active=%b done=%b exp=1/0", active0, done0); end
    @(negedge clk);
    cmd_valid0 = 1'b0;
    #1;
    total++; if (active0 !== 1'b0 || done0 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_end active=%b done=%b exp=0/1", active0, done0); end
    @(negedge clk);
    #1;
    total++; if (done0 !== 1'b0 || inj_count0 !== 8'd2 || err0 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_single done=%b inj=%0d err=%b exp=0/2/0", done0, inj_count0, err0); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    a_in = 1'b0;
    cmd_valid = 1'b0;
    cmd_valid0 = 1'b0;
    cmd_code = 3'd0;
    cmd_dur = 8'd0;
    @(negedge clk);
    test_reset();
    test_idle_inverter();
    test_timed_fault();
    test_permanent_clear();
    test_ignore_illegal();
    test_reset_mid_active();
    test_zero_delay();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
